// File: rtl/riscv_regfile_dump_reader.sv
// Streams a contiguous range of register-file words out through a 2-entry
// output FIFO with valid/ready handshaking; abortable, with a done pulse.
module riscv_regfile_dump_reader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 64
) (
  input  logic                  clk_int,
  input  logic                  rst_n,
  input  logic                  setback_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] first_addr_i,
  input  logic [ADDR_WIDTH-1:0] last_addr_i,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] NREGS = NUM_REGS[ADDR_WIDTH:0];

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
  } entry_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, last_q, last_d;
  entry_t [1:0]          fifo_q, fifo_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  pop, push;
  entry_t                new_e;

  assign raddr_o     = (state_q == READ) ? ptr_q : '0;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = out_valid_o ? fifo_q[0].data : '0;
  assign out_addr_o  = out_valid_o ? fifo_q[0].addr : '0;
  assign out_last_o  = out_valid_o ? fifo_q[0].last : 1'b0;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

  assign pop   = out_valid_o && out_ready_i;
  assign push  = (state_q == READ) && ((cnt_q < 2'd2) || pop);
  assign new_e = '{data: rdata_i, addr: raddr_o, last: (ptr_q == last_q)};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    fifo_d  = fifo_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: if (start_i) begin
        if ((first_addr_i <= last_addr_i) && ({1'b0, last_addr_i} < NREGS)) begin
          ptr_d   = first_addr_i;
          last_d  = last_addr_i;
          state_d = READ;
        end else begin
          done_d  = 1'b1;
        end
      end
      READ: if (push) begin
        if (ptr_q == last_q) state_d = DRAIN;
        else                 ptr_d   = ptr_q + 1'b1;
      end
      DRAIN: if (pop && fifo_q[0].last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Head always lives in slot 0; a pop shifts slot 1 down.
    unique case ({push, pop})
      2'b10: begin
        fifo_d[cnt_q[0]] = new_e;
        cnt_d            = cnt_q + 2'd1;
      end
      2'b01: begin
        fifo_d[0] = fifo_q[1];
        cnt_d     = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          fifo_d[0] = new_e;
        end else begin
          fifo_d[0] = fifo_q[1];
          fifo_d[1] = new_e;
        end
      end
      default: ;
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      ptr_d   = '0;
      last_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      fifo_q  <= '0;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else if (setback_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      fifo_q  <= '0;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      fifo_q  <= fifo_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_riscv_regfile_dump_reader.sv
// Directed bench for riscv_regfile_dump_reader; register file modelled as rdata = addr*3.
module tb_riscv_regfile_dump_reader;

  logic        clk_int = 1'b0;
  logic        rst_n;
  logic        setback;
  logic        start;
  logic [5:0]  first_addr, last_addr;
  logic        abort;
  logic [5:0]  raddr;
  logic [31:0] rdata;
  logic        out_valid, out_ready, out_last, busy, done;
  logic [31:0] out_data;
  logic [5:0]  out_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk_int = ~clk_int;

  assign rdata = 32'(raddr) * 32'd3;

  riscv_regfile_dump_reader #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_REGS(64)) dut (
    .clk_int     (clk_int),
    .rst_n       (rst_n),
    .setback_i   (setback),
    .start_i     (start),
    .first_addr_i(first_addr),
    .last_addr_i (last_addr),
    .abort_i     (abort),
    .raddr_o     (raddr),
    .rdata_i     (rdata),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_addr_o  (out_addr),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"},  64'(out_data),  64'd0);
    chk({tag, "_addr"},  64'(out_addr),  64'd0);
    chk({tag, "_last"},  64'(out_last),  64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_done"},  64'(done),      64'd0);
    chk({tag, "_raddr"}, 64'(raddr),     64'd0);
  endtask

  // Full-rate dump: first word two edges after start, one word per cycle, done after last pop.
  task automatic run_dump(input int f, input int l, input string tag);
    first_addr = 6'(f);
    last_addr  = 6'(l);
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy0"},  64'(busy),      64'd1);
    chk({tag, "_valid0"}, 64'(out_valid), 64'd0);
    chk({tag, "_raddr0"}, 64'(raddr),     64'(f));
    tick();
    for (int a = f; a <= l; a++) begin
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_addr"},  64'(out_addr),  64'(a));
      chk({tag, "_data"},  64'(out_data),  64'(a * 3));
      chk({tag, "_last"},  64'(out_last),  64'(a == l));
      chk({tag, "_nodone"}, 64'(done),     64'd0);
      tick();
    end
    chk({tag, "_valid_end"}, 64'(out_valid), 64'd0);
    chk({tag, "_done"},      64'(done),      64'd1);
    chk({tag, "_busy_end"},  64'(busy),      64'd0);
    tick();
    chk({tag, "_done_1cyc"}, 64'(done),      64'd0);
  endtask

  initial begin
    logic        stall_prev;
    logic [31:0] held_data;
    logic [5:0]  held_addr;
    int          exp_a;
    int          seen_done;

    rst_n = 1'b0; setback = 1'b0; start = 1'b0; abort = 1'b0;
    first_addr = '0; last_addr = '0; out_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Full 32-word dump at full rate.
    run_dump(0, 31, "full");

    // Backpressure: ready toggles every cycle, data must hold while stalled.
    first_addr = 6'd5; last_addr = 6'd8; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    exp_a = 5; seen_done = 0; stall_prev = 1'b0; held_data = '0; held_addr = '0;
    for (int c = 0; c < 40 && seen_done == 0; c++) begin
      out_ready = (c % 2 == 0);
      if (stall_prev) begin
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data",  64'(out_data),  64'(held_data));
        chk("bp_hold_addr",  64'(out_addr),  64'(held_addr));
      end
      if (done) seen_done = 1;
      if (out_valid && out_ready) begin
        chk("bp_addr", 64'(out_addr), 64'(exp_a));
        chk("bp_data", 64'(out_data), 64'(exp_a * 3));
        chk("bp_last", 64'(out_last), 64'(exp_a == 8));
        exp_a++;
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_addr  = out_addr;
      if (seen_done == 0) tick();
    end
    chk("bp_word_count", 64'(exp_a), 64'd9);
    chk("bp_done_seen",  64'(seen_done), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_done_1cyc", 64'(done), 64'd0);

    // Illegal range: done next cycle, nothing emitted, never busy.
    first_addr = 6'd10; last_addr = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_done",  64'(done),      64'd1);
    chk("bad_busy",  64'(busy),      64'd0);
    chk("bad_valid", 64'(out_valid), 64'd0);
    tick();
    chk("bad_done_clr", 64'(done),      64'd0);
    chk("bad_valid2",   64'(out_valid), 64'd0);
    chk("bad_busy2",    64'(busy),      64'd0);

    // Abort with a full FIFO, then a single-word dump.
    first_addr = 6'd0; last_addr = 6'd63; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("abort_pre_valid", 64'(out_valid), 64'd1);
    chk("abort_pre_addr",  64'(out_addr),  64'd0);
    chk("abort_pre_busy",  64'(busy),      64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy",  64'(busy),      64'd0);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_done",  64'(done),      64'd0);
    chk("abort_raddr", 64'(raddr),     64'd0);
    tick();
    chk("abort_done2", 64'(done), 64'd0);
    run_dump(2, 2, "single");

    // Async reset after four words, then a clean full dump.
    first_addr = 6'd0; last_addr = 6'd31; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) begin
      chk("mid_addr", 64'(out_addr), 64'(a));
      if (a < 3) tick();
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("mid_release");
    run_dump(0, 31, "after_rst");

    // start held high during READ with another range must be ignored.
    first_addr = 6'd10; last_addr = 6'd13; out_ready = 1'b1; start = 1'b1;
    tick();
    first_addr = 6'd40; last_addr = 6'd50;
    tick();
    for (int a = 10; a <= 13; a++) begin
      chk("restart_addr", 64'(out_addr), 64'(a));
      chk("restart_last", 64'(out_last), 64'(a == 13));
      if (a == 13) start = 1'b0;
      tick();
    end
    chk("restart_done",  64'(done),      64'd1);
    chk("restart_valid", 64'(out_valid), 64'd0);
    tick();
    chk("restart_idle", 64'(busy), 64'd0);

    // Synchronous setback mid-dump.
    first_addr = 6'd0; last_addr = 6'd20; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("sb_pre_valid", 64'(out_valid), 64'd1);
    setback = 1'b1;
    tick();
    setback = 1'b0;
    chk_all_zero("setback");
    tick();
    chk("sb_no_done", 64'(done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_dump_reader.md
RISCV_REGFILE_DUMP_READER -- requirements
Module: riscv_regfile_dump_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, register-file read address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, register word width.
REQ-003 The block SHALL have parameter NUM_REGS, default 64, number of addressable words, legal range 2..2**ADDR_WIDTH.
REQ-004 The block SHALL have reset rst_n, asynchronous, active-low, and clock clk_int.
REQ-005 Ports (name  direction  width  meaning), clock and reset first:
- clk_int  in  1  clock
- rst_n  in  1  async active-low reset
- setback_i  in  1  synchronous clear; same effect as reset
- start_i  in  1  start a dump; sampled only in IDLE
- first_addr_i  in  ADDR_WIDTH  first register to dump, sampled with start_i
- last_addr_i  in  ADDR_WIDTH  last register to dump, inclusive, sampled with start_i
- abort_i  in  1  cancel the dump in progress
- raddr_o  out  ADDR_WIDTH  register-file read address
- rdata_i  in  DATA_WIDTH  register-file read data, combinational from raddr_o, same cycle
- out_valid_o  out  1  stream word valid
- out_ready_i  in  1  stream consumer ready
- out_data_o  out  DATA_WIDTH  dumped register value
- out_addr_o  out  ADDR_WIDTH  address of out_data_o
- out_last_o  out  1  word is the final word of the dump
- busy_o  out  1  dump in progress (state != IDLE)
- done_o  out  1  one-cycle pulse when a dump completes normally

Function
REQ-006 FSM states SHALL be IDLE, READ and DRAIN.
REQ-007 In IDLE, start_i=1 with first_addr_i<=last_addr_i<NUM_REGS SHALL latch both addresses, load the read pointer with first_addr_i and enter READ on the next edge.
REQ-008 In IDLE, start_i=1 with first_addr_i>last_addr_i or last_addr_i>=NUM_REGS SHALL pulse done_o on the next cycle, stay in IDLE and emit no words.
REQ-009 start_i SHALL be ignored outside IDLE.
REQ-010 raddr_o SHALL equal the read pointer in READ and 0 otherwise.
REQ-011 Output buffering SHALL be a 2-entry FIFO holding {data, addr, last}; out_* SHALL be driven from the FIFO head.
REQ-012 In READ, a read fires in any cycle where the FIFO count is <2, or the count is 2 and a pop occurs in the same cycle; a firing read pushes {rdata_i, raddr_o, raddr_o==last} at the clock edge.
REQ-013 The read pointer SHALL increment by 1 after each fired read; the read of last_addr SHALL move the FSM to DRAIN and the pointer SHALL NOT increment past last_addr.
REQ-014 A pop SHALL occur when out_valid_o && out_ready_i; simultaneous push and pop SHALL keep the count unchanged and preserve order.
REQ-015 out_valid_o SHALL be 1 exactly when the FIFO count is >0; out_data_o, out_addr_o and out_last_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-016 In DRAIN, the FSM SHALL return to IDLE and pulse done_o for one cycle in the cycle after the pop of the out_last_o word.
REQ-017 Throughput with out_ready_i held at 1 SHALL be one word per cycle; first out_valid_o SHALL occur 2 cycles after the start_i cycle.
REQ-018 abort_i in READ or DRAIN SHALL, at the next edge, flush the FIFO, enter IDLE, suppress done_o and take priority over start, push and pop in that cycle; abort_i in IDLE SHALL have no effect.
REQ-019 first_addr_i==last_addr_i SHALL dump exactly one word with out_last_o=1.

Reset
REQ-020 On rst_n=0, and on setback_i=1 at a clock edge, the FSM SHALL be IDLE, FIFO count 0, and pointers 0; all outputs (out_valid_o, out_data_o, out_addr_o, out_last_o, busy_o, done_o, raddr_o) SHALL be 0.
REQ-021 Reset asserted mid-dump SHALL discard all state; no done_o pulse SHALL follow reset release.

Verification
REQ-022 start, first=0, last=31, ready=1, rdata=addr*3 -> 32 words, addr 0..31, data 0..93, one per cycle, last on addr 31, done_o one cycle later.
REQ-023 start, first=5, last=8, ready toggling 1/0 each cycle -> words 5,6,7,8 in order, no drop or duplicate, data held while ready=0, FIFO never exceeds 2.
REQ-024 start, first=10, last=3 -> done_o pulse next cycle, out_valid_o never asserted, busy_o stays 0.
REQ-025 start, first=0, last=63, ready=0 for 20 cycles, abort at cycle 10 -> FIFO flushed, busy_o=0 next cycle, no done_o; a new start, first=2, last=2 -> single word addr 2 with last=1.
REQ-026 rst_n pulsed low mid-dump (after 4 words) -> all outputs 0 immediately, IDLE after release, new start behaves as REQ-022.
REQ-027 start_i reasserted during READ with first=40 -> ignored, original range completes unchanged.
